// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches one word per request/ack handshake,
// holds it for decode, then steps to pc4 / branch / jump. Sticky watchdog on a dead memory.
module if_stage #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [1:0]  pcsource,
    input  logic        id_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        fetch_err
);

    localparam int unsigned CNT_W     = 16;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               imem_req_q, imem_req_d;
    logic               inst_valid_q, inst_valid_d;
    logic               fetch_err_q, fetch_err_d;
    logic [31:0]        pc4_c;
    logic [31:0]        next_pc_c;

    assign pc4_c = pc_q + 32'd4;

    // Next-PC select; targets are word-aligned by dropping the low two bits.
    always_comb begin
        next_pc_c = pc4_c & ALIGN_MASK;
        case (pcsource)
            2'b01:   next_pc_c = bpc & ALIGN_MASK;
            2'b10:   next_pc_c = jpc & ALIGN_MASK;
            default: next_pc_c = pc4_c & ALIGN_MASK;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                state_d    = S_REQ;
                wait_cnt_d = '0;
            end
            S_REQ: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = S_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_HOLD: begin
                if (id_ready) begin
                    pc_d       = next_pc_c;
                    state_d    = S_REQ;
                    wait_cnt_d = '0;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        imem_req_d   = (state_d == S_REQ);
        inst_valid_d = (state_d == S_HOLD);
        fetch_err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            wait_cnt_q   <= '0;
            imem_req_q   <= 1'b0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            wait_cnt_q   <= wait_cnt_d;
            imem_req_q   <= imem_req_d;
            inst_valid_q <= inst_valid_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign pc4        = pc4_c;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a behavioural memory/decode model drives the
// handshake and predicts every fetch address, instruction word and PC update.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned TMO    = 4;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] bpc, jpc;
    logic [1:0]  pcsource;
    logic        id_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc, pc4, inst;
    logic        inst_valid;
    logic        fetch_err;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] exp_pc;

    if_stage #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .clrn(clrn), .bpc(bpc), .jpc(jpc), .pcsource(pcsource),
        .id_ready(id_ready), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .pc4(pc4),
        .inst(inst), .inst_valid(inst_valid), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Decode's view of the next PC: pick the target, then word-align it.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] src,
                                               input logic [31:0] b, input logic [31:0] j);
        logic [31:0] opts [4];
        opts[0] = cur + 32'd4;
        opts[1] = b;
        opts[2] = j;
        opts[3] = cur + 32'd4;
        return opts[src] & 32'hFFFF_FFFC;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete fetch from the first request cycle: lat wait cycles, then hold
    // cycles with decode stalled, then consume with the given select.
    task automatic fetch_one(input int lat, input int hold, input logic [1:0] src,
                             input logic [31:0] b, input logic [31:0] j);
        for (int i = 0; i <= lat; i++) begin
            id_ready   = 1'($urandom);
            imem_ack   = (i == lat);
            imem_rdata = (i == lat) ? mem_word(exp_pc) : $urandom;
            checks++;
            if (imem_req !== 1'b1) begin
                fails++; $display("FAIL req_high cyc%0d got %b want 1", i, imem_req);
            end
            checks++;
            if (imem_addr !== exp_pc) begin
                fails++; $display("FAIL req_addr cyc%0d got %h want %h", i, imem_addr, exp_pc);
            end
            checks++;
            if (inst_valid !== 1'b0) begin
                fails++; $display("FAIL req_valid cyc%0d got %b want 0", i, inst_valid);
            end
            checks++;
            if (fetch_err !== 1'b0) begin
                fails++; $display("FAIL req_err cyc%0d got %b want 0", i, fetch_err);
            end
            tick();
        end
        for (int h = 0; h <= hold; h++) begin
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            id_ready   = (h == hold);
            pcsource   = (h == hold) ? src : 2'($urandom);
            bpc        = (h == hold) ? b : $urandom;
            jpc        = (h == hold) ? j : $urandom;
            checks++;
            if (inst_valid !== 1'b1) begin
                fails++; $display("FAIL hold_valid cyc%0d got %b want 1", h, inst_valid);
            end
            checks++;
            if (imem_req !== 1'b0) begin
                fails++; $display("FAIL hold_req cyc%0d got %b want 0", h, imem_req);
            end
            checks++;
            if (inst !== mem_word(exp_pc)) begin
                fails++; $display("FAIL hold_inst cyc%0d got %h want %h", h, inst, mem_word(exp_pc));
            end
            checks++;
            if (pc !== exp_pc) begin
                fails++; $display("FAIL hold_pc cyc%0d got %h want %h", h, pc, exp_pc);
            end
            checks++;
            if (pc4 !== exp_pc + 32'd4) begin
                fails++; $display("FAIL hold_pc4 cyc%0d got %h want %h", h, pc4, exp_pc + 32'd4);
            end
            tick();
        end
        id_ready = 1'b0;
        imem_ack = 1'b0;
        exp_pc   = model_next(exp_pc, src, b, j);
    endtask

    task automatic test_reset;
        clrn = 1'b0; bpc = '0; jpc = '0; pcsource = 2'b00;
        id_ready = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        tick(); tick();
        checks++;
        if (pc !== RST_PC) begin fails++; $display("FAIL rst_pc got %h want %h", pc, RST_PC); end
        checks++;
        if (pc4 !== RST_PC + 32'd4) begin fails++; $display("FAIL rst_pc4 got %h want %h", pc4, RST_PC + 32'd4); end
        checks++;
        if (inst !== 32'h0) begin fails++; $display("FAIL rst_inst got %h want 0", inst); end
        checks++;
        if (inst_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", inst_valid); end
        checks++;
        if (fetch_err !== 1'b0) begin fails++; $display("FAIL rst_err got %b want 0", fetch_err); end
        clrn = 1'b1;
        checks++;
        if (imem_req !== 1'b0) begin fails++; $display("FAIL idle_req got %b want 0", imem_req); end
        tick();
        exp_pc = RST_PC;
    endtask

    task automatic test_sequential;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (imem_addr !== 32'(4 * k)) begin
                fails++; $display("FAIL seq_addr k%0d got %h want %h", k, imem_addr, 32'(4 * k));
            end
            fetch_one(0, 0, 2'b00, $urandom, $urandom);
        end
    endtask

    task automatic test_branch;
        fetch_one(0, 0, 2'b01, 32'h40, 32'h0);
        checks++;
        if (imem_addr !== 32'h40) begin fails++; $display("FAIL br_bpc got %h want 00000040", imem_addr); end
        fetch_one(0, 0, 2'b10, 32'h0, 32'h10);
        fetch_one(0, 0, 2'b10, 32'h0, 32'h103);
        checks++;
        if (imem_addr !== 32'h100) begin fails++; $display("FAIL br_jpc got %h want 00000100", imem_addr); end
        fetch_one(0, 0, 2'b01, 32'h10, 32'h0);
        fetch_one(0, 0, 2'b11, 32'h40, 32'h80);
        checks++;
        if (imem_addr !== 32'h14) begin fails++; $display("FAIL br_pc4sel got %h want 00000014", imem_addr); end
    endtask

    task automatic test_wait_states;
        fetch_one(3, 5, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 25; k++) begin
            fetch_one(int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, 3)),
                      2'($urandom), $urandom, $urandom);
        end
    endtask

    task automatic test_wrap;
        fetch_one(0, 0, 2'b10, 32'h0, 32'hFFFF_FFFE);
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pc got %h want fffffffc", imem_addr); end
        fetch_one(0, 1, 2'b00, $urandom, $urandom);
        checks++;
        if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_next got %h want 0", imem_addr); end
    endtask

    task automatic test_reset_midfetch;
        fetch_one(0, 0, 2'b01, 32'h20, 32'h0);
        checks++;
        if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin
            fails++; $display("FAIL mid_pre got addr %h req %b want 00000020 1", imem_addr, imem_req);
        end
        #2 clrn = 1'b0;
        #1;
        checks++;
        if (pc !== RST_PC || inst !== 32'h0) begin
            fails++; $display("FAIL mid_async got pc %h inst %h want %h 0", pc, inst, RST_PC);
        end
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            fails++; $display("FAIL mid_outs got req %b valid %b want 0 0", imem_req, inst_valid);
        end
        tick();
        clrn       = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (inst !== 32'h0) begin fails++; $display("FAIL mid_stray got inst %h want 0", inst); end
        checks++;
        if (inst_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b want 0", inst_valid); end
        exp_pc = RST_PC;
        fetch_one(1, 0, 2'b00, $urandom, $urandom);
    endtask

    task automatic test_timeout;
        for (int i = 0; i < int'(TMO); i++) begin
            imem_ack = 1'b0;
            id_ready = 1'($urandom);
            checks++;
            if (imem_req !== 1'b1 || fetch_err !== 1'b0 || imem_addr !== exp_pc) begin
                fails++; $display("FAIL tmo_wait cyc%0d got req %b err %b addr %h want 1 0 %h",
                                  i, imem_req, fetch_err, imem_addr, exp_pc);
            end
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            id_ready   = 1'($urandom);
            checks++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                fails++; $display("FAIL tmo_err cyc%0d got err %b req %b valid %b want 1 0 0",
                                  i, fetch_err, imem_req, inst_valid);
            end
            tick();
        end
        imem_ack = 1'b0;
        id_ready = 1'b0;
        #2 clrn = 1'b0;
        #1;
        checks++;
        if (fetch_err !== 1'b0) begin fails++; $display("FAIL tmo_clear got %b want 0", fetch_err); end
        tick();
        clrn = 1'b1;
        tick();
        exp_pc = RST_PC;
        fetch_one(0, 0, 2'b00, $urandom, $urandom);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_wait_states();
        test_random();
        test_wrap();
        test_reset_midfetch();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the program counter and fetches one instruction per cycle-pair from an instruction memory with a request/acknowledge handshake. It presents `pc`, `pc4` and `inst` to decode, then updates the PC from the decode-supplied branch and jump targets under `pcsource` control. A watchdog counter flags a memory that never acknowledges.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value after reset. Bits [1:0] must be 0.
- `TIMEOUT_CYCLES`, 255: number of consecutive unacknowledged request cycles that trips `fetch_err`. Legal range 1..65535.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: clock; all state updates on the rising edge.
- `clrn`, in, 1: asynchronous active-low reset.
- `bpc`, in, 32: branch target from decode.
- `jpc`, in, 32: jump target from decode.
- `pcsource`, in, 2: next-PC select. 00 = pc4, 01 = bpc, 10 = jpc, 11 = pc4.
- `id_ready`, in, 1: decode consumes the presented instruction this cycle.
- `imem_req`, out, 1: fetch request.
- `imem_addr`, out, 32: fetch address; always equals `pc`.
- `imem_ack`, in, 1: memory returns data this cycle; may be asserted in the same cycle as `imem_req`.
- `imem_rdata`, in, 32: instruction word; valid when `imem_ack`=1.
- `pc`, out, 32: address of the held instruction.
- `pc4`, out, 32: `pc`+4, combinational, modulo 2^32.
- `inst`, out, 32: registered instruction word.
- `inst_valid`, out, 1: `inst` is valid for decode.
- `fetch_err`, out, 1: sticky watchdog error.

## Operation
States:
- `S_IDLE`: the reset state. Always moves to `S_REQ` on the next edge.
- `S_REQ`:
  - `imem_req`=1.
  - On `imem_ack`=1: `inst` <= `imem_rdata`, go to `S_HOLD`.
  - Otherwise: the wait counter increments. When the counter equals `TIMEOUT_CYCLES`-1 with no ack, go to `S_ERR`.
- `S_HOLD`:
  - `inst_valid`=1, `imem_req`=0.
  - On `id_ready`=1: `pc` <= next_pc, go to `S_REQ`, clear the wait counter.
  - Otherwise hold `pc`, `inst` and state.
- `S_ERR`:
  - `fetch_err`=1, `imem_req`=0, `inst_valid`=0.
  - Exits only through reset.

Rules:
- next_pc = mux(`pcsource`) with bits [1:0] forced to 00. Only the `bpc`, `jpc` and `pcsource` values present in the cycle `id_ready`=1 matter.
- `imem_ack` is ignored outside `S_REQ`. `id_ready` is ignored outside `S_HOLD`.
- The wait counter is 16 bits and cleared on every entry to `S_REQ`. It never wraps, because the error trips first.
- `pc4` wraps: a `pc` of 32'hFFFF_FFFC gives a `pc4` of 32'h0000_0000.

## Timing
- Reset values (asserted immediately and asynchronously):
  - state = `S_IDLE`
  - `pc` = `RESET_PC`
  - `inst` = 0
  - `inst_valid` = 0
  - `imem_req` = 0
  - `fetch_err` = 0
  - wait counter = 0
- First `imem_req`: the first cycle after the first rising edge with `clrn`=1.
- Zero-wait memory: ack in the request cycle gives `inst_valid` on the next cycle.
- Throughput with zero-wait memory and `id_ready` tied high: one instruction per 2 cycles.
- Memory latency of N wait cycles: `inst_valid` rises N+1 cycles after `imem_req` rises.
- Outputs are stable:
  - `inst`, `pc` and `pc4` stay stable for the whole `S_HOLD` period.
  - `imem_addr` stays stable for the whole `S_REQ` period.
- `fetch_err` timing: asserts on the edge after the `TIMEOUT_CYCLES`-th consecutive unacknowledged request cycle.
- Reset mid-fetch: any outstanding request is abandoned, and a late `imem_ack` after reset is ignored because the block is in `S_IDLE`.

## Test plan
- Reset then zero-wait memory, `id_ready`=1, `pcsource`=00 -> `imem_addr` sequence 0, 4, 8, one address every 2 cycles. `inst` matches the memory contents. `pc4` = `pc`+4.
- In `S_HOLD` with `pc`=0x10: `pcsource`=01, `bpc`=0x40 -> next fetch at 0x40. `pcsource`=10, `jpc`=0x103 -> next fetch at 0x100. `pcsource`=11 -> 0x14.
- Memory with a 3-cycle wait -> `imem_req` high for 4 cycles and `imem_addr` stable. `inst_valid` rises on the 5th cycle. Holding `id_ready` low for 5 cycles keeps `inst`/`pc` unchanged and `imem_req`=0.
- Never-acking memory with `TIMEOUT_CYCLES`=4 -> `fetch_err`=1 after 4 request cycles, then `imem_req`=0 permanently. Asserting `clrn`=0 clears `fetch_err`.
- `clrn` pulsed low during `S_REQ` with `pc`=0x20 and `imem_ack` asserted one cycle after release -> `pc`=`RESET_PC`, `inst`=0. The stray ack does not load `inst`. The first request after reset targets `RESET_PC`.
- `pc`=0xFFFF_FFFC, `pcsource`=00, `id_ready`=1 -> `pc4`=0 and next fetch at address 0.
